uart_char_rx: RTL and testbench

// - Serial front end for the UCI command path: deserialises 8N1 UART from the host, buffers bytes in a FIFO,
//   and presents them on a valid/ready byte stream that feeds the UCI handler's char_in/char_in_valid/char_in_ready.
// - Strips optional CR (0x0D) so CRLF hosts produce the bare LF (0x0A) line terminator the command parser expects.

---
 rtl/uart_char_rx_if.sv | 13 +
 rtl/uart_char_rx.sv | 135 +++++++++++++
 tb/tb_uart_char_rx.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_char_rx_if.sv
// Byte stream handshake between the UART receiver and its consumer.
//   char_out        received byte, head of the receive FIFO
//   char_out_valid  char_out holds a byte
//   char_out_ready  consumer accepts char_out this cycle
// master: byte source (receiver), slave: byte sink (command handler).
interface uart_char_rx_if;
  logic [7:0] char_out;
  logic       char_out_valid;
  logic       char_out_ready;

  modport master (output char_out, output char_out_valid, input char_out_ready);
  modport slave  (input char_out, input char_out_valid, output char_out_ready);
endinterface

// File: rtl/uart_char_rx.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Optionally discards CR bytes so CRLF hosts deliver a bare LF terminator.
//   clk_in     system clock, rising edge
//   rst_in     synchronous active-high reset
//   rx_in      asynchronous UART line, idle high
//   char_if    byte stream out (char_out / char_out_valid / char_out_ready)
//   overflow   sticky: a byte was dropped because the FIFO was full
//   frame_err  one-cycle pulse: stop bit sampled low, byte discarded
module uart_char_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_CR      = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_in,
  uart_char_rx_if.master        char_if,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta, rx_s;
  logic          tick, sample_data, push_req, ferr_nxt;

  // ---------------- receive FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    sample_data = 1'b0;
    push_req    = 1'b0;
    ferr_nxt    = 1'b0;
    // Start bit is checked at its midpoint; every later sample is a full bit apart.
    tick = (state == START) ? (baud_cnt == HALF_M1) : (baud_cnt == FULL_M1);
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick) begin
                   sample_data = 1'b1;
                   if (bit_idx == 3'd7) state_nxt = STOP;
                 end
      STOP:      if (tick) begin
                   if (rx_s) begin
                     push_req  = 1'b1;
                     state_nxt = IDLE;
                   end else begin
                     ferr_nxt  = 1'b1;
                     state_nxt = WAIT_IDLE;
                   end
                 end
      // A held-low (break) line must return high before a new start is accepted.
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx_in;
      rx_s      <= rx_meta;
      frame_err <= ferr_nxt;
      if (state == IDLE || tick) baud_cnt <= '0;
      else                       baud_cnt <= baud_cnt + CW'(1);
      if (state == IDLE) bit_idx <= '0;
      else if (sample_data) begin
        shreg   <= {rx_s, shreg[7:1]};   // LSB first
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ---------------- receive FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic          is_cr, full, pop, push, drop, empty_nxt;
  logic [7:0]    head_nxt;

  always_comb begin
    is_cr      = (DROP_CR != 0) && (shreg == 8'h0D);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = char_if.char_out_valid && char_if.char_out_ready;
    push       = push_req && !is_cr && (!full || pop);
    drop       = push_req && !is_cr && full && !pop;
    rd_ptr_nxt = rd_ptr + PW'(pop);
    wr_ptr_nxt = wr_ptr + PW'(push);
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    // A byte written into the slot that becomes the head must bypass mem,
    // since the write and the head register update land on the same edge.
    head_nxt   = (push && wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]) ? shreg
                                                                 : mem[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr                 <= '0;
      rd_ptr                 <= '0;
      char_if.char_out       <= '0;
      char_if.char_out_valid <= 1'b0;
      overflow               <= 1'b0;
    end else begin
      wr_ptr                 <= wr_ptr_nxt;
      rd_ptr                 <= rd_ptr_nxt;
      char_if.char_out_valid <= !empty_nxt;
      if (!empty_nxt) char_if.char_out <= head_nxt;
      if (drop)       overflow         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_char_rx.sv
module tb_uart_char_rx;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic ovf, ferr, ovf0, ferr0;

  uart_char_rx_if cif ();
  uart_char_rx_if cif0 ();

  uart_char_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DROP_CR(1)) dut (
    .clk_in(clk), .rst_in(rst), .rx_in(rx), .char_if(cif), .overflow(ovf), .frame_err(ferr));

  uart_char_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .DROP_CR(0)) dut_nocr (
    .clk_in(clk), .rst_in(rst), .rx_in(rx), .char_if(cif0), .overflow(ovf0), .frame_err(ferr0));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] rxq[$];
  logic [7:0] rxq0[$];
  int         stampq[$];
  int         ferr_cnt = 0;

  // Outputs sampled mid-cycle; inputs only change #1 after the rising edge.
  always @(negedge clk) begin
    if (cif.char_out_valid && cif.char_out_ready) begin
      rxq.push_back(cif.char_out);
      stampq.push_back(cyc);
    end
    if (cif0.char_out_valid && cif0.char_out_ready) rxq0.push_back(cif0.char_out);
    if (ferr) ferr_cnt++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  initial begin
    cif.char_out_ready  = 1'b0;
    cif0.char_out_ready = 1'b1;
    tick(4);
    chk("rst_valid", {31'd0, cif.char_out_valid}, 32'd0);
    chk("rst_char", {24'd0, cif.char_out}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_ferr", {31'd0, ferr}, 32'd0);
    rst = 1'b0;
    tick(4);

    // "go\n" with ready high
    cif.char_out_ready = 1'b1;
    rxq.delete(); ferr_cnt = 0;
    send_byte(8'h67, 1'b1);
    send_byte(8'h6F, 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(20);
    chk("go_count", rxq.size(), 32'd3);
    if (rxq.size() == 3) begin
      chk("go_b0", {24'd0, rxq[0]}, 32'h67);
      chk("go_b1", {24'd0, rxq[1]}, 32'h6F);
      chk("go_b2", {24'd0, rxq[2]}, 32'h0A);
    end
    chk("go_ovf", {31'd0, ovf}, 32'd0);
    chk("go_ferr", ferr_cnt, 32'd0);

    // short glitch below half a bit
    rxq.delete();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    chk("glitch_none", rxq.size(), 32'd0);
    send_byte(8'h55, 1'b1);
    tick(20);
    chk("glitch_next_cnt", rxq.size(), 32'd1);
    if (rxq.size() == 1) chk("glitch_next_val", {24'd0, rxq[0]}, 32'h55);

    // framing error followed by held-low line
    rxq.delete(); ferr_cnt = 0;
    send_byte(8'h41, 1'b0);
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(16);
    send_byte(8'h42, 1'b1);
    tick(20);
    chk("ferr_pulses", ferr_cnt, 32'd1);
    chk("ferr_count", rxq.size(), 32'd1);
    if (rxq.size() == 1) chk("ferr_val", {24'd0, rxq[0]}, 32'h42);

    // CR handling: dut drops CR, dut_nocr passes it
    rxq.delete(); rxq0.delete();
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(20);
    chk("cr_drop_cnt", rxq.size(), 32'd1);
    if (rxq.size() == 1) chk("cr_drop_val", {24'd0, rxq[0]}, 32'h0A);
    chk("cr_pass_cnt", rxq0.size(), 32'd2);
    if (rxq0.size() == 2) begin
      chk("cr_pass_b0", {24'd0, rxq0[0]}, 32'h0D);
      chk("cr_pass_b1", {24'd0, rxq0[1]}, 32'h0A);
    end

    // overflow with consumer stalled
    rxq.delete(); stampq.delete();
    cif.char_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b1);
    tick(4);
    chk("ovf_before", {31'd0, ovf}, 32'd0);
    chk("ovf_valid", {31'd0, cif.char_out_valid}, 32'd1);
    chk("ovf_hold", {24'd0, cif.char_out}, 32'h31);
    send_byte(8'h35, 1'b1);
    tick(4);
    chk("ovf_after", {31'd0, ovf}, 32'd1);
    cif.char_out_ready = 1'b1;
    tick(10);
    chk("ovf_count", rxq.size(), 32'd4);
    if (rxq.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("ovf_val", {24'd0, rxq[i]}, 32'h31 + i);
      chk("ovf_b2b", stampq[3] - stampq[0], 32'd3);
    end
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // reset during data bit 3 of 0x7A; sender abandons the frame
    rxq.delete();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);   // 0x7A bits 0..2 = 0,1,0
      tick(CPB);
    end
    rx = 1'b1;         // bit 3 = 1
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, cif.char_out_valid}, 32'd0);
    chk("mid_rst_char", {24'd0, cif.char_out}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    chk("mid_rst_ferr", {31'd0, ferr}, 32'd0);
    tick(40);
    chk("mid_rst_none", rxq.size(), 32'd0);
    send_byte(8'h62, 1'b1);
    tick(20);
    chk("post_rst_cnt", rxq.size(), 32'd1);
    if (rxq.size() == 1) chk("post_rst_val", {24'd0, rxq[0]}, 32'h62);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
